// File: rtl/axil_rd_if.sv
// AXI-Lite read-channel bundle (AR + R) shared by the upstream and downstream
// sides of axil_arb_rd.
interface axil_rd_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_arb_rd.sv
// Two-master AXI-Lite read arbiter with one outstanding read and local DECERR
// for out-of-window addresses. Define AXIL_ARB_RD_RR_EN for round-robin grants.
module axil_arb_rd #(
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] SLV_BASE       = 32'h0000_0000,
    parameter logic [AXI_ADDR_WIDTH-1:0] SLV_SIZE       = 32'h0001_0000
) (
    input  logic        aclk,
    input  logic        areset,
    axil_rd_if.slave    s_axil_0,
    axil_rd_if.slave    s_axil_1,
    axil_rd_if.master   m_axil,
    output logic        slv_invalid,
    output logic        busy
);
    localparam int AW = AXI_ADDR_WIDTH;
    localparam int DW = AXI_DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

    state_t state_q, state_d;
    logic   gnt_q, gnt_d;
    logic   inv_q, inv_d;
    logic   busy_q;

    logic [AW-1:0] s_araddr  [2];
    logic          s_arvalid [2];
    logic          s_rready  [2];
    logic          s_arready [2];
    logic [DW-1:0] s_rdata   [2];
    logic [1:0]    s_rresp   [2];
    logic          s_rvalid  [2];

    assign s_araddr[0]  = s_axil_0.araddr;
    assign s_arvalid[0] = s_axil_0.arvalid;
    assign s_rready[0]  = s_axil_0.rready;
    assign s_araddr[1]  = s_axil_1.araddr;
    assign s_arvalid[1] = s_axil_1.arvalid;
    assign s_rready[1]  = s_axil_1.rready;

    assign s_axil_0.arready = s_arready[0];
    assign s_axil_0.rdata   = s_rdata[0];
    assign s_axil_0.rresp   = s_rresp[0];
    assign s_axil_0.rvalid  = s_rvalid[0];
    assign s_axil_1.arready = s_arready[1];
    assign s_axil_1.rdata   = s_rdata[1];
    assign s_axil_1.rresp   = s_rresp[1];
    assign s_axil_1.rvalid  = s_rvalid[1];

    // One extra bit keeps SLV_BASE+SLV_SIZE from wrapping at the top of the map.
    logic [AW-1:0] addr_sel;
    logic [AW:0]   addr_x, lo_x, hi_x;
    logic          hit;

    assign addr_sel = s_araddr[gnt_q];
    assign addr_x   = {1'b0, addr_sel};
    assign lo_x     = {1'b0, SLV_BASE};
    assign hi_x     = lo_x + {1'b0, SLV_SIZE};
    assign hit      = (SLV_SIZE != '0) && (addr_x >= lo_x) && (addr_x < hi_x);

`ifdef AXIL_ARB_RD_RR_EN
    logic last_gnt_q;
`endif

    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        inv_d          = inv_q;
        m_axil.araddr  = '0;
        m_axil.arvalid = 1'b0;
        m_axil.rready  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_arready[i] = 1'b0;
            s_rdata[i]   = '0;
            s_rresp[i]   = 2'b00;
            s_rvalid[i]  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (s_arvalid[0] || s_arvalid[1]) begin
                    state_d = ADDR;
`ifdef AXIL_ARB_RD_RR_EN
                    if (s_arvalid[0] && s_arvalid[1])
                        gnt_d = ~last_gnt_q;
                    else
                        gnt_d = ~s_arvalid[0];
`else
                    gnt_d = ~s_arvalid[0];
`endif
                end
            end
            ADDR: begin
                if (hit) begin
                    m_axil.araddr    = addr_sel;
                    m_axil.arvalid   = s_arvalid[gnt_q];
                    s_arready[gnt_q] = m_axil.arready;
                    if (s_arvalid[gnt_q] && m_axil.arready)
                        state_d = DATA;
                end else begin
                    // Miss: accept the address locally, never present it downstream.
                    s_arready[gnt_q] = 1'b1;
                    inv_d            = 1'b1;
                    state_d          = ERR;
                end
            end
            DATA: begin
                s_rdata[gnt_q]  = m_axil.rdata;
                s_rresp[gnt_q]  = m_axil.rresp;
                s_rvalid[gnt_q] = m_axil.rvalid;
                m_axil.rready   = s_rready[gnt_q];
                if (m_axil.rvalid && s_rready[gnt_q])
                    state_d = IDLE;
            end
            ERR: begin
                s_rvalid[gnt_q] = 1'b1;
                s_rresp[gnt_q]  = 2'b11;
                if (s_rready[gnt_q]) begin
                    inv_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            inv_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            inv_q   <= inv_d;
            busy_q  <= (state_d != IDLE);
        end
    end

`ifdef AXIL_ARB_RD_RR_EN
    always_ff @(posedge aclk) begin
        if (areset)
            last_gnt_q <= 1'b1;
        else if (state_q == IDLE && state_d == ADDR)
            last_gnt_q <= gnt_d;
    end
`endif

    assign slv_invalid = inv_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_axil_arb_rd.sv
// Bench for axil_arb_rd: table of single reads plus hand sequences for
// simultaneous requests, R back-pressure and mid-transaction reset.
module tb_axil_arb_rd;
    logic aclk;
    logic areset;
    logic slv_invalid;
    logic busy;

    axil_rd_if #(.AW(32), .DW(32)) s0_if ();
    axil_rd_if #(.AW(32), .DW(32)) s1_if ();
    axil_rd_if #(.AW(32), .DW(32)) m_if ();

    axil_arb_rd dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_axil_0    (s0_if),
        .s_axil_1    (s1_if),
        .m_axil      (m_if),
        .slv_invalid (slv_invalid),
        .busy        (busy)
    );

    localparam bit RR =
`ifdef AXIL_ARB_RD_RR_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct {
        logic        m;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    typedef struct {
        logic        m;
        logic [31:0] addr;
        int          dly;
        logic        fwd;
        logic [31:0] data;
        logic [1:0]  resp;
    } vec_t;

    exp_t        exp_q[$];
    logic [31:0] req0_q[$];
    logic [31:0] req1_q[$];
    vec_t        vecs[6];

    int          n_chk = 0;
    int          n_fail = 0;
    int          ar_delay = 0;
    int          m_hs_cnt = 0;
    int          cnt_marv = 0;
    int          cnt_inv = 0;
    logic [31:0] last_m_addr = '0;
    logic        model_last;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [31:0] slave_f(input logic [31:0] a);
        return 32'hDEAD_BEFF ^ a;
    endfunction

    function automatic logic [1:0] slave_r(input logic [31:0] a);
        return a[3] ? 2'b10 : 2'b00;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: condition not reached within cycle budget", name);
    endtask

    task automatic got_beat(input logic m, input logic [31:0] d, input logic [1:0] r);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL r_unexpected: master %0d got %h/%b with nothing expected", m, d, r);
        end else begin
            e = exp_q.pop_front();
            chk("r_beat", 64'({m, d, r}), 64'({e.m, e.data, e.resp}));
            $display("R beat: master %0d rdata=%h rresp=%b (expected master %0d %h/%b)",
                     m, d, r, e.m, e.data, e.resp);
        end
    endtask

    // Scoreboard monitor: R handshakes are seen at negedge, completing at the next posedge.
    initial begin
        forever begin
            @(negedge aclk);
            if (s0_if.rvalid && s0_if.rready) got_beat(1'b0, s0_if.rdata, s0_if.rresp);
            if (s1_if.rvalid && s1_if.rready) got_beat(1'b1, s1_if.rdata, s1_if.rresp);
            if (m_if.arvalid) cnt_marv++;
            if (slv_invalid)  cnt_inv++;
        end
    end

    // Master 0 AR driver
    initial begin
        logic hs;
        s0_if.arvalid = 1'b0;
        s0_if.araddr  = '0;
        forever begin
            @(negedge aclk);
            hs = s0_if.arvalid && s0_if.arready;
            @(posedge aclk);
            #1;
            if (hs || areset) s0_if.arvalid = 1'b0;
            if (!s0_if.arvalid && req0_q.size() > 0) begin
                s0_if.araddr  = req0_q.pop_front();
                s0_if.arvalid = 1'b1;
            end
        end
    end

    // Master 1 AR driver
    initial begin
        logic hs;
        s1_if.arvalid = 1'b0;
        s1_if.araddr  = '0;
        forever begin
            @(negedge aclk);
            hs = s1_if.arvalid && s1_if.arready;
            @(posedge aclk);
            #1;
            if (hs || areset) s1_if.arvalid = 1'b0;
            if (!s1_if.arvalid && req1_q.size() > 0) begin
                s1_if.araddr  = req1_q.pop_front();
                s1_if.arvalid = 1'b1;
            end
        end
    end

    // Downstream slave model with programmable AR delay
    initial begin
        logic        ar_hs, r_hs, av, rst;
        logic [31:0] a;
        int          cnt;
        cnt = 0;
        m_if.arready = 1'b0;
        m_if.rvalid  = 1'b0;
        m_if.rdata   = '0;
        m_if.rresp   = 2'b00;
        forever begin
            @(negedge aclk);
            ar_hs = m_if.arvalid && m_if.arready;
            r_hs  = m_if.rvalid && m_if.rready;
            av    = m_if.arvalid;
            a     = m_if.araddr;
            rst   = areset;
            @(posedge aclk);
            #1;
            if (rst) begin
                m_if.arready = 1'b0;
                m_if.rvalid  = 1'b0;
                cnt = 0;
            end else begin
                if (r_hs) m_if.rvalid = 1'b0;
                if (ar_hs) begin
                    m_if.arready = 1'b0;
                    m_if.rvalid  = 1'b1;
                    m_if.rdata   = slave_f(a);
                    m_if.rresp   = slave_r(a);
                    last_m_addr  = a;
                    m_hs_cnt++;
                    cnt = 0;
                end else if (av && !m_if.arready) begin
                    if (cnt >= ar_delay) m_if.arready = 1'b1;
                    else cnt++;
                end
            end
        end
    end

    task automatic wait_idle(input string tag, input int budget);
        bit done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge aclk);
            if (exp_q.size() == 0 && req0_q.size() == 0 && req1_q.size() == 0 &&
                !busy && !s0_if.arvalid && !s1_if.arvalid)
                done = 1'b1;
        end
        if (!done) fail_now({tag, "_timeout"});
    endtask

    task automatic run_one(input vec_t v, input string tag);
        int h0  = m_hs_cnt;
        int mv0 = cnt_marv;
        int iv0 = cnt_inv;
        bit done = 1'b0;
        ar_delay = v.dly;
        @(negedge aclk);
        exp_q.push_back('{v.m, v.data, v.resp});
        if (v.m) req1_q.push_back(v.addr);
        else     req0_q.push_back(v.addr);
        model_last = v.m;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge aclk);
            if (v.m)
                chk({tag, "_m0_quiet"}, 64'({s0_if.arready, s0_if.rvalid, s0_if.rdata, s0_if.rresp}), 64'd0);
            else
                chk({tag, "_m1_quiet"}, 64'({s1_if.arready, s1_if.rvalid, s1_if.rdata, s1_if.rresp}), 64'd0);
            if (exp_q.size() == 0 && !busy && !s0_if.arvalid && !s1_if.arvalid)
                done = 1'b1;
        end
        if (!done) fail_now({tag, "_timeout"});
        chk({tag, "_fwd_count"}, 64'(m_hs_cnt - h0), 64'(v.fwd));
        chk({tag, "_marvalid_seen"}, 64'(cnt_marv != mv0), 64'(v.fwd));
        chk({tag, "_slv_invalid_seen"}, 64'(cnt_inv != iv0), 64'(!v.fwd));
        if (v.fwd) chk({tag, "_m_araddr"}, 64'(last_m_addr), 64'(v.addr));
        $display("Read: master %0d addr=%h fwd=%0d expected %h/%b", v.m, v.addr, v.fwd, v.data, v.resp);
    endtask

    task automatic simul_round(input string tag);
        logic w;
        int   h0 = m_hs_cnt;
        w = RR ? ~model_last : 1'b0;
        ar_delay = 1;
        @(negedge aclk);
        if (w) begin
            exp_q.push_back('{1'b1, slave_f(32'h30), slave_r(32'h30)});
            exp_q.push_back('{1'b0, slave_f(32'h20), slave_r(32'h20)});
        end else begin
            exp_q.push_back('{1'b0, slave_f(32'h20), slave_r(32'h20)});
            exp_q.push_back('{1'b1, slave_f(32'h30), slave_r(32'h30)});
        end
        req0_q.push_back(32'h20);
        req1_q.push_back(32'h30);
        model_last = ~w;
        wait_idle(tag, 80);
        chk({tag, "_fwd_count"}, 64'(m_hs_cnt - h0), 64'd2);
        $display("Simultaneous: expected order %0d then %0d", w, ~w);
    endtask

    initial begin
        bit seen;
        areset        = 1'b1;
        s0_if.rready  = 1'b1;
        s1_if.rready  = 1'b1;
        model_last    = 1'b1;

        vecs[0] = '{1'b0, 32'h0000_0010, 2, 1'b1, 32'hDEAD_BEEF, 2'b00};
        vecs[1] = '{1'b1, 32'h0002_0000, 0, 1'b0, 32'h0000_0000, 2'b11};
        vecs[2] = '{1'b0, 32'h0000_FFFF, 1, 1'b1, 32'hDEAD_4100, 2'b10};
        vecs[3] = '{1'b1, 32'h0001_0000, 0, 1'b0, 32'h0000_0000, 2'b11};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF, 0, 1'b0, 32'h0000_0000, 2'b11};
        vecs[5] = '{1'b1, 32'h0000_0008, 0, 1'b1, 32'hDEAD_BEF7, 2'b10};

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_slv_invalid", 64'(slv_invalid), 64'd0);
        chk("reset_outputs", 64'({s0_if.arready, s0_if.rvalid, s1_if.arready, s1_if.rvalid,
                                  m_if.arvalid, m_if.rready}), 64'd0);
        @(posedge aclk);
        #1 areset = 1'b0;

        for (int i = 0; i < 6; i++) run_one(vecs[i], $sformatf("vec%0d", i));

        simul_round("simul_a");
        simul_round("simul_b");

        // R back-pressure on master 0 while master 1 waits.
        @(posedge aclk);
        #1 s0_if.rready = 1'b0;
        ar_delay = 1;
        @(negedge aclk);
        exp_q.push_back('{1'b0, 32'hDEAD_BEBF, 2'b00});
        req0_q.push_back(32'h40);
        @(negedge aclk);
        exp_q.push_back('{1'b1, 32'hDEAD_BEBB, 2'b00});
        req1_q.push_back(32'h44);
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge aclk);
            if (s0_if.rvalid) seen = 1'b1;
        end
        if (!seen) fail_now("bp_rvalid");
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge aclk);
            chk("bp_m1_arready", 64'(s1_if.arready), 64'd0);
            chk("bp_m0_rvalid_held", 64'(s0_if.rvalid), 64'd1);
            chk("bp_m_arvalid", 64'(m_if.arvalid), 64'd0);
        end
        @(posedge aclk);
        #1 s0_if.rready = 1'b1;
        wait_idle("bp", 60);
        model_last = 1'b1;

        // Reset while in DATA aborts the read.
        @(posedge aclk);
        #1 s0_if.rready = 1'b0;
        ar_delay = 0;
        @(negedge aclk);
        req0_q.push_back(32'h50);
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge aclk);
            if (m_if.rvalid && busy) seen = 1'b1;
        end
        if (!seen) fail_now("rst_reach_data");
        @(posedge aclk);
        #1 areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        s0_if.rready = 1'b1;
        exp_q.delete();
        model_last = 1'b1;
        @(negedge aclk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_slv_invalid", 64'(slv_invalid), 64'd0);
        chk("rst_s0_outputs", 64'({s0_if.arready, s0_if.rvalid, s0_if.rdata, s0_if.rresp}), 64'd0);
        chk("rst_m_outputs", 64'({m_if.arvalid, m_if.rready, m_if.araddr}), 64'd0);

        run_one('{1'b0, 32'h0000_0100, 3, 1'b1, 32'hDEAD_BFFF, 2'b00}, "recover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axil_arb_rd.md
Name: axil_arb_rd

Overview:
AXI-Lite read-channel arbiter and sequencer. Two upstream masters share one downstream slave read port. Upstream grants use fixed priority, with master 0 highest. The grant is held from AR acceptance until R completes, so only one read is outstanding at a time. Addresses outside the slave window are never forwarded; the block answers them locally with DECERR. It sits ahead of the read-channel slave mux and produces that mux's select.

Parameters:
AXI_DATA_WIDTH, 32, RDATA width
AXI_ADDR_WIDTH, 32, ARADDR width
SLV_BASE, 32'h0000_0000, first valid address of the slave window
SLV_SIZE, 32'h0001_0000, window size in bytes; valid iff SLV_BASE <= araddr < SLV_BASE+SLV_SIZE

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  synchronous, active-high reset
s_axil_araddr_0  in  AXI_ADDR_WIDTH  master 0 read address
s_axil_arvalid_0  in  1  master 0 AR valid
s_axil_arready_0  out  1  master 0 AR ready
s_axil_rdata_0  out  AXI_DATA_WIDTH  master 0 read data
s_axil_rresp_0  out  2  master 0 read response
s_axil_rvalid_0  out  1  master 0 R valid
s_axil_rready_0  in  1  master 0 R ready
s_axil_*_1  (same set, same directions/widths)  master 1
m_axil_araddr  out  AXI_ADDR_WIDTH  slave read address
m_axil_arvalid  out  1  slave AR valid
m_axil_arready  in  1  slave AR ready
m_axil_rdata  in  AXI_DATA_WIDTH  slave read data
m_axil_rresp  in  2  slave read response
m_axil_rvalid  in  1  slave R valid
m_axil_rready  out  1  slave R ready
slv_invalid  out  1  registered; 1 while the current transaction is a local DECERR
busy  out  1  registered; 1 in any state other than IDLE

Behaviour:
- FSM: IDLE, ADDR, DATA, ERR. A registered grant bit gnt selects master 0 or 1.
- Reset (areset=1 at an edge): state=IDLE, gnt=0, slv_invalid=0, busy=0.
- Every ready, valid and data output is 0 in IDLE and for the non-granted master in all states.
- Reset mid-transaction aborts the transaction. Nothing is replayed.
- IDLE:
  - If s_arvalid_0=1: gnt<=0, go to ADDR.
  - Else if s_arvalid_1=1: gnt<=1, go to ADDR.
  - Simultaneous requests: master 0 wins.
  - No ready is asserted in IDLE, giving one cycle of arbitration latency.
- ADDR, decode hit (address inside the window, computed combinationally from s_araddr[gnt]):
  - m_araddr=s_araddr[gnt], m_arvalid=s_arvalid[gnt], s_arready[gnt]=m_arready.
  - On handshake, go to DATA.
- ADDR, decode miss:
  - m_arvalid=0, s_arready[gnt]=1 for one cycle.
  - slv_invalid<=1, go to ERR.
- Window arithmetic: compute in AXI_ADDR_WIDTH+1 bits so SLV_BASE+SLV_SIZE does not wrap. If SLV_SIZE=0, every address misses.
- DATA:
  - s_rdata/s_rresp/s_rvalid[gnt] = m_rdata/m_rresp/m_rvalid; m_rready=s_rready[gnt].
  - On R handshake, go to IDLE.
  - Slave rresp passes through unchanged.
- ERR:
  - s_rvalid[gnt]=1, s_rresp=2'b11, s_rdata=0.
  - On s_rready[gnt]=1, clear slv_invalid and go to IDLE.
- A master keeping arvalid high after its R completes re-arbitrates in IDLE. The priority rule applies again.
- Minimum transaction length: 3 cycles (IDLE, ADDR, DATA/ERR), with no back-to-back overlap.
- Back-pressure in ADDR and DATA may last indefinitely. Grant and state are held; no timeout.

Optional Feature:
Macro AXIL_ARB_RD_RR_EN.
- Defined: round-robin arbitration.
  - A register last_gnt (reset 1) records the master granted most recently.
  - On a simultaneous request, the master with index != last_gnt wins.
  - last_gnt updates on the IDLE->ADDR transition.
- Undefined: fixed priority as above. No last_gnt register exists.

Test Plan:
1. Master 0 reads 0x0000_0010; slave returns rdata=0xDEAD_BEEF, rresp=00 with 2 cycles arready delay -> master 0 gets 0xDEAD_BEEF/00; m_araddr=0x10; master 1 outputs stay 0.
2. Both masters assert arvalid in the same cycle (0x20 and 0x30) -> master 0 is served first, then master 1. With AXIL_ARB_RD_RR_EN and two repeated rounds, grants alternate 0,1,0,1.
3. Master 1 reads 0x0002_0000 (outside the default window) -> m_arvalid stays 0, slv_invalid=1, master 1 gets rresp=11, rdata=0, then busy=0.
4. Master 0 holds rready=0 for 5 cycles in DATA with master 1 requesting -> the grant stays on master 0, master 1 sees no arready until master 0's R handshake completes.
5. Assert areset for 1 cycle while in DATA -> next cycle state=IDLE, all outputs 0, busy=0, slv_invalid=0.
6. Boundary addresses SLV_BASE+SLV_SIZE-1 and SLV_BASE+SLV_SIZE -> the first is forwarded to the slave, the second returns DECERR.
